// File: rtl/dlx_mac_burst.sv
// dlx_mac_burst: single/burst memory access controller on the AS_N/WR_N/ACK_N bus.
// Define DLX_MAC_TIMEOUT_EN to enable the REQ watchdog that aborts to DONE and sets err.
module dlx_mac_burst #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255,
  localparam int BLEN_W   = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BLEN_W-1:0] blen,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] DI,
  input  logic              ACK_N,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] AO,
  output logic [DATA_W-1:0] DO,
  output logic              AS_N,
  output logic              WR_N,
  output logic [1:0]        MAC_STATE_OUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              wr_q;
  logic [BLEN_W-1:0] beats_left;
  logic [BLEN_W-1:0] eff_len;
  logic              accept;
  logic              beat_ack;
  logic              timeout_hit;

  assign accept        = (state == IDLE) && req;
  assign beat_ack      = (state == REQ) && !ACK_N;
  assign MAC_STATE_OUT = state;

  always_comb begin
    eff_len = blen;
    if (blen == '0)
      eff_len = BLEN_W'(1);
    else if (blen > BLEN_W'(MAX_BURST))
      eff_len = BLEN_W'(MAX_BURST);
  end

`ifdef DLX_MAC_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] wd_cnt;

  // The TIMEOUT-th REQ cycle without an acknowledge is the one that aborts.
  assign timeout_hit = (state == REQ) && ACK_N && (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state_n == REQ) && (state != REQ))
        wd_cnt <= '0;
      else if ((state == REQ) && ACK_N)
        wd_cnt <= wd_cnt + CNT_W'(1);
      if (accept)
        err <= 1'b0;
      else if (timeout_hit)
        err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req) state_n = REQ;
      REQ: begin
        if (!ACK_N)
          state_n = REC;
        else if (timeout_hit)
          state_n = DONE;
      end
      REC:  state_n = (beats_left != '0) ? REQ : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus strobes and status flags are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q       <= 1'b0;
      beats_left <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      wready     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      AO         <= '0;
      DO         <= '0;
      AS_N       <= 1'b1;
      WR_N       <= 1'b1;
    end else begin
      rvalid <= 1'b0;
      wready <= 1'b0;
      busy   <= (state_n != IDLE);
      done   <= (state_n == DONE);
      AS_N   <= !(state_n == REQ);
      WR_N   <= !((state_n == REQ) && (accept ? wr : wr_q));
      if (accept) begin
        wr_q       <= wr;
        AO         <= addr;
        DO         <= wdata;
        beats_left <= eff_len;
      end
      if (state == REC) begin
        AO <= AO + ADDR_W'(DATA_W / 8);
        if (state_n == REQ)
          DO <= wdata;
      end
      if (beat_ack) begin
        beats_left <= beats_left - BLEN_W'(1);
        if (wr_q) begin
          wready <= 1'b1;
        end else begin
          rvalid <= 1'b1;
          rdata  <= DI;
        end
      end
    end
  end

endmodule
